// File: rtl/ctrl_pipeline.sv
// Pipelined control path for a classic five-stage MIPS-style core.
// Carries decode control bits through the ID/EX, EX/MEM and MEM/WB stage
// registers. Also resolves load-use stalls and branch/jump flushes, and
// counts how many stall cycles were inserted.
module ctrl_pipeline (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  Ctrl_ID,
    input  logic        Branch_ID,
    input  logic        Jump_ID,
    input  logic [4:0]  Rs_ID,
    input  logic [4:0]  Rt_ID,
    input  logic        Zero_EX,
    output logic        RegDst_EX,
    output logic [1:0]  ALUOp_EX,
    output logic        ALUSrc_EX,
    output logic        Branch_EX,
    output logic        Jump_EX,
    output logic        MemRead_MEM,
    output logic        MemWrite_MEM,
    output logic        RegWrite_MEM,
    output logic        RegWrite_WB,
    output logic        MemtoReg_WB,
    output logic        PCSrc,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic [15:0] StallCount
);

    // What the hazard unit decided for the instruction currently in ID
    typedef enum logic [1:0] {
        NORMAL,
        STALL,
        FLUSH
    } hazardMode_t;

    localparam logic [15:0] STALL_COUNT_MAX = 16'hFFFF;

    // ID/EX stage register.
    // The control word layout is {RegDst, ALUOp[1:0], ALUSrc, MemRead, MemWrite, RegWrite, MemtoReg}.
    logic [7:0]  idExCtrl;
    logic        idExBranch;
    logic        idExJump;
    logic [4:0]  idExRt;

    // EX/MEM stage register
    logic        exMemMemRead;
    logic        exMemMemWrite;
    logic        exMemRegWrite;
    logic        exMemMemtoReg;

    // MEM/WB stage register
    logic        memWbRegWrite;
    logic        memWbMemtoReg;

    logic [15:0] stallCnt;

    logic        pcSrc;
    logic        loadUse;
    hazardMode_t hazardMode;

    // Hazard detection: a taken branch/jump overrides a load-use stall
    always_comb begin
        pcSrc      = 1'b0;
        loadUse    = 1'b0;
        hazardMode = NORMAL;
        pcSrc      = idExBranch & (idExJump | Zero_EX);
        loadUse    = idExCtrl[3] && (idExRt != 5'd0) &&
                     ((idExRt == Rs_ID) || (idExRt == Rt_ID));
        if (pcSrc) begin
            hazardMode = FLUSH;
        end else if (loadUse) begin
            hazardMode = STALL;
        end
    end

    // Front-end controls derived from the hazard decision
    always_comb begin
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        IFIDFlush = 1'b0;
        PCSrc     = pcSrc;
        if (hazardMode == STALL) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
        end else if (hazardMode == FLUSH) begin
            IFIDFlush = 1'b1;
        end
    end

    // ID/EX takes the decoded instruction, or a bubble when stalling or flushing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idExCtrl   <= 8'd0;
            idExBranch <= 1'b0;
            idExJump   <= 1'b0;
            idExRt     <= 5'd0;
        end else if (hazardMode == NORMAL) begin
            idExCtrl   <= Ctrl_ID;
            idExBranch <= Branch_ID;
            idExJump   <= Jump_ID;
            idExRt     <= Rt_ID;
        end else begin
            idExCtrl   <= 8'd0;
            idExBranch <= 1'b0;
            idExJump   <= 1'b0;
            idExRt     <= 5'd0;
        end
    end

    // EX/MEM and MEM/WB always advance, so older instructions drain during stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exMemMemRead  <= 1'b0;
            exMemMemWrite <= 1'b0;
            exMemRegWrite <= 1'b0;
            exMemMemtoReg <= 1'b0;
            memWbRegWrite <= 1'b0;
            memWbMemtoReg <= 1'b0;
        end else begin
            exMemMemRead  <= idExCtrl[3];
            exMemMemWrite <= idExCtrl[2];
            exMemRegWrite <= idExCtrl[1];
            exMemMemtoReg <= idExCtrl[0];
            memWbRegWrite <= exMemRegWrite;
            memWbMemtoReg <= exMemMemtoReg;
        end
    end

    // Saturating count of cycles lost to load-use stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCnt <= 16'd0;
        end else if ((hazardMode == STALL) && (stallCnt != STALL_COUNT_MAX)) begin
            stallCnt <= stallCnt + 16'd1;
        end
    end

    assign RegDst_EX    = idExCtrl[7];
    assign ALUOp_EX     = idExCtrl[6:5];
    assign ALUSrc_EX    = idExCtrl[4];
    assign Branch_EX    = idExBranch;
    assign Jump_EX      = idExJump;
    assign MemRead_MEM  = exMemMemRead;
    assign MemWrite_MEM = exMemMemWrite;
    assign RegWrite_MEM = exMemRegWrite;
    assign RegWrite_WB  = memWbRegWrite;
    assign MemtoReg_WB  = memWbMemtoReg;
    assign StallCount   = stallCnt;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Testbench for ctrl_pipeline.
// Each vector lists the inputs held during one cycle and the outputs
// expected during that same cycle. Expectations are queued when a vector
// is driven and popped when the outputs are sampled on the falling edge.
module tb_ctrl_pipeline;

    logic        clk;
    logic        rst;
    logic [7:0]  Ctrl_ID;
    logic        Branch_ID;
    logic        Jump_ID;
    logic [4:0]  Rs_ID;
    logic [4:0]  Rt_ID;
    logic        Zero_EX;
    logic        RegDst_EX;
    logic [1:0]  ALUOp_EX;
    logic        ALUSrc_EX;
    logic        Branch_EX;
    logic        Jump_EX;
    logic        MemRead_MEM;
    logic        MemWrite_MEM;
    logic        RegWrite_MEM;
    logic        RegWrite_WB;
    logic        MemtoReg_WB;
    logic        PCSrc;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        IFIDFlush;
    logic [15:0] StallCount;

    ctrl_pipeline dut (
        .clk          (clk),
        .rst          (rst),
        .Ctrl_ID      (Ctrl_ID),
        .Branch_ID    (Branch_ID),
        .Jump_ID      (Jump_ID),
        .Rs_ID        (Rs_ID),
        .Rt_ID        (Rt_ID),
        .Zero_EX      (Zero_EX),
        .RegDst_EX    (RegDst_EX),
        .ALUOp_EX     (ALUOp_EX),
        .ALUSrc_EX    (ALUSrc_EX),
        .Branch_EX    (Branch_EX),
        .Jump_EX      (Jump_EX),
        .MemRead_MEM  (MemRead_MEM),
        .MemWrite_MEM (MemWrite_MEM),
        .RegWrite_MEM (RegWrite_MEM),
        .RegWrite_WB  (RegWrite_WB),
        .MemtoReg_WB  (MemtoReg_WB),
        .PCSrc        (PCSrc),
        .PCWrite      (PCWrite),
        .IFIDWrite    (IFIDWrite),
        .IFIDFlush    (IFIDFlush),
        .StallCount   (StallCount)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ex  = {RegDst, ALUOp[1:0], ALUSrc, Branch, Jump}
    // mem = {MemRead, MemWrite, RegWrite}
    // wb  = {RegWrite, MemtoReg}
    // pc  = {PCSrc, PCWrite, IFIDWrite, IFIDFlush}
    typedef struct {
        logic [7:0]  ctrl;
        logic        br;
        logic        jp;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        zero;
        logic [5:0]  ex;
        logic [2:0]  mem;
        logic [1:0]  wb;
        logic [3:0]  pc;
        logic [15:0] cnt;
    } vecRec_t;

    typedef struct {
        logic [30:0] value;
        string       tag;
    } expRec_t;

    expRec_t expQ[$];
    vecRec_t vectors[24];
    int      checkCount = 0;
    int      errorCount = 0;

    function automatic vecRec_t mk(input logic [7:0] c, input logic b, input logic j,
                                   input logic [4:0] rs, input logic [4:0] rt, input logic z,
                                   input logic [5:0] ex, input logic [2:0] mem,
                                   input logic [1:0] wb, input logic [3:0] pc,
                                   input logic [15:0] cnt);
        vecRec_t v;
        v.ctrl = c;  v.br = b;   v.jp = j;   v.rs = rs; v.rt = rt; v.zero = z;
        v.ex = ex;   v.mem = mem; v.wb = wb; v.pc = pc; v.cnt = cnt;
        return v;
    endfunction

    function automatic logic [30:0] packActual();
        return {RegDst_EX, ALUOp_EX, ALUSrc_EX, Branch_EX, Jump_EX,
                MemRead_MEM, MemWrite_MEM, RegWrite_MEM,
                RegWrite_WB, MemtoReg_WB,
                PCSrc, PCWrite, IFIDWrite, IFIDFlush, StallCount};
    endfunction

    // Drive one cycle of inputs (optionally just after a rising edge) and queue its expectation
    task automatic applyStimulus(input vecRec_t v, input string tag, input bit alignEdge);
        expRec_t e;
        if (alignEdge) begin
            @(posedge clk);
            #1;
        end
        Ctrl_ID   = v.ctrl;
        Branch_ID = v.br;
        Jump_ID   = v.jp;
        Rs_ID     = v.rs;
        Rt_ID     = v.rt;
        Zero_EX   = v.zero;
        e.value   = {v.ex, v.mem, v.wb, v.pc, v.cnt};
        e.tag     = tag;
        expQ.push_back(e);
    endtask

    // Sample outputs (on the falling edge, or shortly after a mid-cycle event) and compare
    task automatic checkOutput(input bit waitNegedge);
        expRec_t     e;
        logic [30:0] act;
        if (waitNegedge) @(negedge clk);
        else #1;
        checkCount++;
        if (expQ.size() == 0) begin
            errorCount++;
            $display("[TB] FAIL scoreboard-empty actual=%h required=entry", packActual());
            return;
        end
        e   = expQ.pop_front();
        act = packActual();
        if (act !== e.value) begin
            errorCount++;
            $display("[TB] FAIL %s actual ctl=%b cnt=%h required ctl=%b cnt=%h",
                     e.tag, act[30:16], act[15:0], e.value[30:16], e.value[15:0]);
        end
    endtask

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence
    initial begin
        rst       = 1'b0;
        Ctrl_ID   = 8'd0;
        Branch_ID = 1'b0;
        Jump_ID   = 1'b0;
        Rs_ID     = 5'd0;
        Rt_ID     = 5'd0;
        Zero_EX   = 1'b0;

        //            ctrl         br    jp    rs     rt     z       ex         mem     wb     pc        cnt
        vectors[0]  = mk(8'b11000010, 1'b0, 1'b0, 5'd1, 5'd2, 1'b0, 6'b000000, 3'b000, 2'b00, 4'b0110, 16'd0);
        vectors[1]  = mk(8'b00000000, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 6'b110000, 3'b000, 2'b00, 4'b0110, 16'd0);
        vectors[2]  = mk(8'b00000000, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 6'b000000, 3'b001, 2'b00, 4'b0110, 16'd0);
        vectors[3]  = mk(8'b00011011, 1'b0, 1'b0, 5'd3, 5'd8, 1'b0, 6'b000000, 3'b000, 2'b10, 4'b0110, 16'd0);
        vectors[4]  = mk(8'b11000010, 1'b0, 1'b0, 5'd8, 5'd9, 1'b0, 6'b000100, 3'b000, 2'b00, 4'b0000, 16'd0);
        vectors[5]  = mk(8'b11000010, 1'b0, 1'b0, 5'd8, 5'd9, 1'b0, 6'b000000, 3'b101, 2'b00, 4'b0110, 16'd1);
        vectors[6]  = mk(8'b00011011, 1'b0, 1'b0, 5'd4, 5'd0, 1'b0, 6'b110000, 3'b000, 2'b11, 4'b0110, 16'd1);
        vectors[7]  = mk(8'b11000010, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 6'b000100, 3'b001, 2'b00, 4'b0110, 16'd1);
        vectors[8]  = mk(8'b00100000, 1'b1, 1'b0, 5'd1, 5'd2, 1'b0, 6'b110000, 3'b101, 2'b10, 4'b0110, 16'd1);
        vectors[9]  = mk(8'b11000010, 1'b0, 1'b0, 5'd5, 5'd6, 1'b1, 6'b001010, 3'b001, 2'b11, 4'b1111, 16'd1);
        vectors[10] = mk(8'b00001000, 1'b1, 1'b0, 5'd1, 5'd8, 1'b0, 6'b000000, 3'b000, 2'b10, 4'b0110, 16'd1);
        vectors[11] = mk(8'b11000010, 1'b0, 1'b0, 5'd8, 5'd8, 1'b1, 6'b000010, 3'b000, 2'b00, 4'b1111, 16'd1);
        vectors[12] = mk(8'b00000000, 1'b0, 1'b0, 5'd8, 5'd8, 1'b0, 6'b000000, 3'b100, 2'b00, 4'b0110, 16'd1);
        vectors[13] = mk(8'b00000000, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 6'b000000, 3'b000, 2'b00, 4'b0110, 16'd1);
        vectors[14] = mk(8'b00000000, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 6'b000011, 3'b000, 2'b00, 4'b1111, 16'd1);
        vectors[15] = mk(8'b00000000, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 6'b000000, 3'b000, 2'b00, 4'b0110, 16'd1);
        vectors[16] = mk(8'b00000000, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 6'b000001, 3'b000, 2'b00, 4'b0110, 16'd1);
        vectors[17] = mk(8'b00011011, 1'b0, 1'b0, 5'd3, 5'd8, 1'b0, 6'b000000, 3'b000, 2'b00, 4'b0110, 16'd1);
        vectors[18] = mk(8'b00011011, 1'b0, 1'b0, 5'd8, 5'd9, 1'b0, 6'b000100, 3'b000, 2'b00, 4'b0000, 16'd1);
        vectors[19] = mk(8'b00011011, 1'b0, 1'b0, 5'd8, 5'd9, 1'b0, 6'b000000, 3'b101, 2'b00, 4'b0110, 16'd2);
        vectors[20] = mk(8'b11000010, 1'b0, 1'b0, 5'd1, 5'd9, 1'b0, 6'b000100, 3'b000, 2'b11, 4'b0000, 16'd2);
        vectors[21] = mk(8'b11000010, 1'b0, 1'b0, 5'd1, 5'd9, 1'b0, 6'b000000, 3'b101, 2'b00, 4'b0110, 16'd3);
        vectors[22] = mk(8'b00000000, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 6'b110000, 3'b000, 2'b11, 4'b0110, 16'd3);
        vectors[23] = mk(8'b00000000, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 6'b000000, 3'b001, 2'b00, 4'b0110, 16'd3);

        // Power-on reset state, before any clock edge
        #2;
        applyStimulus(mk(8'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0,
                         6'b000000, 3'b000, 2'b00, 4'b0110, 16'd0), "reset-initial", 1'b0);
        checkOutput(1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Table-driven main sequence
        for (int i = 0; i < 24; i++) begin
            applyStimulus(vectors[i], $sformatf("vec%0d", i), 1'b1);
            checkOutput(1'b1);
        end

        // Reset asserted mid-stall: outputs clear at once and the pending bubble is discarded
        applyStimulus(mk(8'b00011011, 1'b0, 1'b0, 5'd3, 5'd8, 1'b0,
                         6'b000000, 3'b000, 2'b10, 4'b0110, 16'd3), "pre-reset-load", 1'b1);
        checkOutput(1'b1);
        applyStimulus(mk(8'b11000010, 1'b0, 1'b0, 5'd8, 5'd1, 1'b0,
                         6'b000100, 3'b000, 2'b00, 4'b0000, 16'd3), "pre-reset-stall", 1'b1);
        checkOutput(1'b1);
        #1;
        rst = 1'b0;
        applyStimulus(mk(8'b11000010, 1'b0, 1'b0, 5'd8, 5'd1, 1'b0,
                         6'b000000, 3'b000, 2'b00, 4'b0110, 16'd0), "reset-midcycle", 1'b0);
        checkOutput(1'b0);
        #1;
        rst = 1'b1;
        applyStimulus(mk(8'b00000000, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0,
                         6'b110000, 3'b000, 2'b00, 4'b0110, 16'd0), "post-reset-normal", 1'b1);
        checkOutput(1'b1);

        // Counter saturation: preset near the top, then stall twice
        applyStimulus(mk(8'b00011011, 1'b0, 1'b0, 5'd3, 5'd8, 1'b0,
                         6'b000000, 3'b001, 2'b00, 4'b0110, 16'd0), "sat-load1", 1'b1);
        checkOutput(1'b1);
        applyStimulus(mk(8'b11000010, 1'b0, 1'b0, 5'd8, 5'd2, 1'b0,
                         6'b000100, 3'b000, 2'b10, 4'b0000, 16'hFFFE), "sat-stall1", 1'b1);
        force dut.stallCnt = 16'hFFFE;
        #1;
        release dut.stallCnt;
        checkOutput(1'b1);
        applyStimulus(mk(8'b00011011, 1'b0, 1'b0, 5'd0, 5'd8, 1'b0,
                         6'b000000, 3'b101, 2'b00, 4'b0110, 16'hFFFF), "sat-reach-max", 1'b1);
        checkOutput(1'b1);
        applyStimulus(mk(8'b11000010, 1'b0, 1'b0, 5'd1, 5'd8, 1'b0,
                         6'b000100, 3'b000, 2'b11, 4'b0000, 16'hFFFF), "sat-stall2", 1'b1);
        checkOutput(1'b1);
        applyStimulus(mk(8'b00000000, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0,
                         6'b000000, 3'b101, 2'b00, 4'b0110, 16'hFFFF), "sat-hold", 1'b1);
        checkOutput(1'b1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
